// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions: format constants, result
// classes and the classifier used by the add/sub result stage and later stages.
package fp_pkg;

    localparam int          FP_W    = 32;
    localparam int          CLS_W   = 3;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_NAN    = 3'd4
    } fp_class_e;

    function automatic fp_class_e fp_classify(input logic [FP_W-1:0] value);
        logic [7:0]  exp_s;
        logic [22:0] frac_s;
        fp_class_e   cls_s;
        exp_s  = value[30:23];
        frac_s = value[22:0];
        if (exp_s == 8'h00) begin
            cls_s = (frac_s == 23'd0) ? CLS_ZERO : CLS_DENORM;
        end else if (exp_s == EXP_MAX) begin
            cls_s = (frac_s == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            cls_s = CLS_NORMAL;
        end
        return cls_s;
    endfunction

endpackage

// File: rtl/fp_skid_buffer.sv
// Generic two-entry valid/ready skid buffer. The main register drives the
// output; the skid register absorbs one beat of back-pressure. in_ready is registered.
module fp_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid_r;
    logic [DATA_W-1:0] main_data_r;
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              in_ready_r;

    logic              main_valid_s;
    logic [DATA_W-1:0] main_data_s;
    logic              skid_valid_s;
    logic [DATA_W-1:0] skid_data_s;
    logic              accept_s;
    logic              emit_s;

    assign accept_s = in_valid & in_ready_r;
    assign emit_s   = main_valid_r & out_ready;

    // Next-state for both entries; skid only fills when main is full and stalled
    always_comb begin
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (skid_valid_r) begin
            if (emit_s) begin
                main_data_s  = skid_data_r;
                main_valid_s = 1'b1;
                skid_valid_s = 1'b0;
            end else begin
                main_valid_s = 1'b1;
            end
        end else if (accept_s) begin
            if (!main_valid_r || emit_s) begin
                main_data_s  = in_data;
                main_valid_s = 1'b1;
            end else begin
                skid_data_s  = in_data;
                skid_valid_s = 1'b1;
            end
        end else if (emit_s) begin
            main_valid_s = 1'b0;
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // Entry registers and the registered ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {DATA_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            main_data_r  <= main_data_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            in_ready_r   <= ~skid_valid_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

endmodule

// File: rtl/fp_addsub_result_stage.sv
// Registered output stage of the FP add/sub unit: classify, NaN-canonicalise,
// skid-buffer and track exception status. Define FP_RESULT_FLUSH_DENORM_EN to flush denormals.
module fp_addsub_result_stage
    import fp_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int EXC_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_result,
    input  logic                 in_exception,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [2:0]           out_class,
    output logic                 out_exception,
    output logic                 out_sub,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 sticky_exc,
    output logic [EXC_CNT_W-1:0] exc_count,
    input  logic                 clr_status
);

    localparam int PAYLOAD_W = FP_W + CLS_W + 2 + TAG_W;
    localparam logic [EXC_CNT_W-1:0] CNT_ONE = {{(EXC_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EXC_CNT_W-1:0] CNT_MAX = {EXC_CNT_W{1'b1}};
`ifdef FP_RESULT_FLUSH_DENORM_EN
    localparam logic FLUSH_DENORM = 1'b1;
`else
    localparam logic FLUSH_DENORM = 1'b0;
`endif

    fp_class_e              raw_class_s;
    fp_class_e              xf_class_s;
    logic [FP_W-1:0]        xf_result_s;
    logic [PAYLOAD_W-1:0]   pay_in_s;
    logic [PAYLOAD_W-1:0]   pay_out_s;
    logic                   skid_in_ready_s;
    logic                   accept_exc_s;
    logic                   sticky_exc_r;
    logic [EXC_CNT_W-1:0]   exc_count_r;

    assign raw_class_s = fp_classify(in_result);

    // Exceptional results become the canonical quiet NaN; optional denormal flush keeps the sign
    always_comb begin
        xf_result_s = in_result;
        xf_class_s  = raw_class_s;
        if (in_exception) begin
            xf_result_s = FP_QNAN;
            xf_class_s  = CLS_NAN;
        end else if (FLUSH_DENORM && (raw_class_s == CLS_DENORM)) begin
            xf_result_s = {in_result[31], 31'd0};
            xf_class_s  = CLS_ZERO;
        end else begin
            xf_result_s = in_result;
            xf_class_s  = raw_class_s;
        end
    end

    assign pay_in_s = {xf_result_s, xf_class_s, in_exception, in_sub, in_tag};

    fp_skid_buffer #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (skid_in_ready_s),
        .in_data   (pay_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out_s)
    );

    assign in_ready = skid_in_ready_s;
    assign {out_result, out_class, out_exception, out_sub, out_tag} = pay_out_s;

    assign accept_exc_s = in_valid & skid_in_ready_s & in_exception;

    // Sticky flag and saturating counter; a same-cycle clear still counts the new exception
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_exc_r <= 1'b0;
            exc_count_r  <= {EXC_CNT_W{1'b0}};
        end else if (clr_status) begin
            sticky_exc_r <= accept_exc_s;
            exc_count_r  <= accept_exc_s ? CNT_ONE : {EXC_CNT_W{1'b0}};
        end else if (accept_exc_s) begin
            sticky_exc_r <= 1'b1;
            if (exc_count_r != CNT_MAX) begin
                exc_count_r <= exc_count_r + CNT_ONE;
            end else begin
                exc_count_r <= exc_count_r;
            end
        end else begin
            sticky_exc_r <= sticky_exc_r;
            exc_count_r  <= exc_count_r;
        end
    end

    assign sticky_exc = sticky_exc_r;
    assign exc_count  = exc_count_r;

endmodule

// File: doc/fp_addsub_result_stage.md
Name: fp_addsub_result_stage

Overview:
- Registered output stage directly downstream of the combinational IEEE-754 single-precision add/sub unit.
- Captures each result word plus its exception flag and an issue tag behind a valid/ready handshake.
- Classifies each result, replaces exceptional results with a canonical quiet NaN, and keeps sticky exception status and a saturating exception counter for software.
- A 2-entry skid buffer decouples the arithmetic unit from back-pressure.

Parameters:
- TAG_W, 4, width of the per-operation tag carried alongside the result.
- EXC_CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a beat.
- in_result  input  32  IEEE-754 result from the add/sub unit.
- in_exception  input  1  add/sub exception flag (an operand exponent was 255).
- in_sub  input  1  operation was a subtraction (1) or an addition (0).
- in_tag  input  TAG_W  issue tag.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_result  output  32  final result word.
- out_class  output  3  0 ZERO, 1 DENORM, 2 NORMAL, 3 INF, 4 NAN.
- out_exception  output  1  registered copy of in_exception.
- out_sub  output  1  registered copy of in_sub.
- out_tag  output  TAG_W  registered copy of in_tag.
- sticky_exc  output  1  set when any exceptional beat is accepted.
- exc_count  output  EXC_CNT_W  number of accepted exceptional beats, saturating.
- clr_status  input  1  single-cycle pulse that clears sticky_exc and exc_count.

Behaviour:
- Clock and reset: single clock domain, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_result=0, out_class=0, out_exception=0, out_sub=0, out_tag=0, sticky_exc=0, exc_count=0. Reset asserted mid-operation discards both buffer entries on the next edge.
- Handshake:
  - Accept occurs when in_valid & in_ready. Emit occurs when out_valid & out_ready.
  - Payload must remain stable while valid is high and ready is low.
  - Latency is one cycle: a beat accepted at edge N is visible on out_* after edge N when the main register is free.
- Skid buffer:
  - Two registers: main (drives out_*) and skid.
  - in_ready is a registered signal equal to ~skid_valid; there is no combinational path from out_ready to in_ready.
  - Accept while main is empty, or while main is emitting: the beat loads main.
  - Accept while main is full and not emitting: the beat loads skid, and in_ready drops the next cycle.
  - Emit while skid is full: skid moves to main and skid empties; in_ready rises the next cycle.
  - Accept and emit in the same cycle with skid empty: main reloads with no bubble.
  - Order is strictly FIFO. No beat is dropped or duplicated.
- Pre-register transform (applied at accept):
  - If in_exception=1: stored result is 32'h7FC00000 and class is NAN.
  - Otherwise classify from in_result:
    - exponent 0, fraction 0 -> ZERO
    - exponent 0, fraction nonzero -> DENORM
    - exponent 255, fraction 0 -> INF
    - exponent 255, fraction nonzero -> NAN
    - any other -> NORMAL
  - Signed zero is kept as given: 32'h80000000 -> ZERO with the sign preserved.
- Status:
  - Updates on accepted beats only, not on emitted beats.
  - An accept with in_exception=1 sets sticky_exc and increments exc_count. The counter saturates at all-ones and does not wrap.
  - clr_status alone: both cleared next cycle.
  - clr_status together with an accepted exceptional beat: sticky_exc=1, exc_count=1.

Optional Feature:
- Macro: FP_RESULT_FLUSH_DENORM_EN.
- Defined: any non-exceptional DENORM result is flushed to signed zero {sign, 31'b0} and classified ZERO.
- Undefined: denormals pass through unchanged with class DENORM.
- Status logic is unaffected by the macro in both cases.

Decomposition:
- Shared package fp_pkg:
  - localparams: FP_QNAN=32'h7FC00000, EXP_MAX=8'hFF, FP_W=32.
  - class enum/constants: CLS_ZERO..CLS_NAN (3 bits).
  - classify function (shared with future stages).
- One natural sub-module: fp_skid_buffer, a generic 2-entry valid/ready skid buffer parameterised by payload width. This stage instantiates it with payload {result, class, exception, sub, tag}.

Test Plan:
- Reset, then send in_result=32'h40400000 (1.0+2.0), tag=3, out_ready=1 -> one cycle later out_valid=1, out_result=32'h40400000, class=2, tag=3, exc_count=0.
- in_exception=1, in_result=0 -> out_result=32'h7FC00000, class=4, sticky_exc=1, exc_count=1. Pulse clr_status -> both 0.
- out_ready=0, push tags 1, 2 -> in_ready=0 after the second accept, tag 3 held. Release out_ready -> tags emitted in order 1, 2, 3 with no loss.
- in_result=32'h00000001: without the macro -> class 1, unchanged. With FP_RESULT_FLUSH_DENORM_EN -> 32'h00000000, class 0. Input 32'h80000001 with the macro -> 32'h80000000.
- EXC_CNT_W=2, send 5 exceptional beats -> exc_count=3 (saturated). clr_status in the same cycle as a 6th exceptional accept -> exc_count=1.
- Stream 100 random beats with random out_ready toggles, then assert rst mid-stream -> next cycle out_valid=0, in_ready=1, and all status registers zero.
